dl_bus_sequencer: RTL and testbench

Bus-cycle sequencer for the 8-bit data latch between the core and the ASIC data bus. It arbitrates one-M-cycle memory accesses between the CPU core and the DMA engine. It steps each granted access through four T-states and drives the latch controls `DL_Control1` (bus connect, active-low) and `DL_Control2` (ALU result → DL), plus the external `rd`/`wr`/`addr` strobes. It sits beside the data latch, fed by the instruction sequencer and the DMA controller.

---
 rtl/dl_seq_pkg.sv | 23 ++
 rtl/dl_bus_sequencer_if.sv | 33 +++
 rtl/dl_seq_arbiter.sv | 41 ++++
 rtl/dl_bus_sequencer.sv | 113 +++++++++++
 tb/tb_dl_bus_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dl_seq_pkg.sv
// Shared types and constants for the data-latch bus sequencer.
// The FSM, the arbiter and the bench use this package.
package dl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int T_STATES = 4;

  // A burst limit of 0 still needs a 1-bit counter so the width stays legal.
  function automatic int run_cnt_w(input int burst);
    return (burst > 0) ? $clog2(burst + 1) : 1;
  endfunction

endpackage

// File: rtl/dl_bus_sequencer_if.sv
// Request side (CPU core, DMA engine) and bus/latch control side of the sequencer.
// The sequencer takes the slave modport.
interface dl_bus_sequencer_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;

  logic [15:0] addr;
  logic        DL_Control1;
  logic        DL_Control2;
  logic        dl_capture;
  logic        rd;
  logic        wr;
  logic        cpu_ack;
  logic        dma_ack;
  logic        owner;
  logic        busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, dma_req, dma_we, dma_addr,
    input  addr, DL_Control1, DL_Control2, dl_capture, rd, wr,
           cpu_ack, dma_ack, owner, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, dma_req, dma_we, dma_addr,
    output addr, DL_Control1, DL_Control2, dl_capture, rd, wr,
           cpu_ack, dma_ack, owner, busy
  );
endinterface

// File: rtl/dl_seq_arbiter.sv
// CPU/DMA winner select with a bounded DMA run length.
// The run counter only moves at arbitration points.
module dl_seq_arbiter
  import dl_seq_pkg::*;
#(
  parameter int DMA_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb_en,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_grant,
  output logic o_grant_dma
);

  localparam int              CW      = run_cnt_w(DMA_BURST);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DMA_BURST);

  logic [CW-1:0] r_run_cnt;
  logic          w_cpu_turn;

  always_comb begin
    w_cpu_turn  = (DMA_BURST != 0) && i_cpu_req && (r_run_cnt == CNT_MAX);
    o_grant_dma = i_dma_req && !w_cpu_turn;
    o_grant     = o_grant_dma || i_cpu_req;
  end

  // Counts DMA grants that made a waiting CPU stand aside; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
    end else if (i_arb_en) begin
      if (!i_cpu_req || !o_grant_dma)
        r_run_cnt <= '0;
      else if (r_run_cnt != CNT_MAX)
        r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dl_bus_sequencer.sv
// Four-T-state M-cycle sequencer for the core/ASIC data latch.
// Outputs are registered from the next-state decode so they line up with the state.
module dl_bus_sequencer
  import dl_seq_pkg::*;
#(
  parameter int DMA_BURST = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  dl_bus_sequencer_if.slave   bus
);

  state_e      r_state, w_nxt_state;
  logic        r_we, w_nxt_we;
  logic        r_owner, w_nxt_owner;
  logic [15:0] r_addr, w_nxt_addr;

  logic r_dl1, r_dl2, r_cap, r_rd, r_wr, r_cack, r_dack, r_busy;
  logic w_nxt_dl1, w_nxt_dl2, w_nxt_cap, w_nxt_rd, w_nxt_wr;
  logic w_nxt_cack, w_nxt_dack, w_nxt_busy;

  logic w_arb_en, w_grant, w_grant_dma;

  assign w_arb_en = (r_state == ST_IDLE) || (r_state == ST_T4);

  dl_seq_arbiter #(.DMA_BURST(DMA_BURST)) u_arb (
    .clk         (CLK),
    .rst         (RESET),
    .i_arb_en    (w_arb_en),
    .i_cpu_req   (bus.cpu_req),
    .i_dma_req   (bus.dma_req),
    .o_grant     (w_grant),
    .o_grant_dma (w_grant_dma)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_we    = r_we;
    w_nxt_owner = r_owner;
    w_nxt_addr  = r_addr;
    case (r_state)
      ST_IDLE, ST_T4: begin
        if (w_grant) begin
          w_nxt_state = ST_T1;
          w_nxt_owner = w_grant_dma ? OWN_DMA : OWN_CPU;
          w_nxt_we    = w_grant_dma ? bus.dma_we   : bus.cpu_we;
          w_nxt_addr  = w_grant_dma ? bus.dma_addr : bus.cpu_addr;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_T1:   w_nxt_state = ST_T2;
      ST_T2:   w_nxt_state = ST_T3;
      ST_T3:   w_nxt_state = ST_T4;
      default: w_nxt_state = ST_IDLE;
    endcase

    w_nxt_busy = (w_nxt_state != ST_IDLE);
    w_nxt_dl1  = (w_nxt_state == ST_IDLE);
    w_nxt_dl2  = (w_nxt_state == ST_T1) && w_nxt_we;
    w_nxt_rd   = !w_nxt_we && ((w_nxt_state == ST_T2) || (w_nxt_state == ST_T3));
    w_nxt_wr   =  w_nxt_we && ((w_nxt_state == ST_T2) || (w_nxt_state == ST_T3));
    w_nxt_cap  = !w_nxt_we && (w_nxt_state == ST_T3);
    w_nxt_cack = (w_nxt_state == ST_T4) && (w_nxt_owner == OWN_CPU);
    w_nxt_dack = (w_nxt_state == ST_T4) && (w_nxt_owner == OWN_DMA);
  end

  // Reset abandons any in-flight access: no ack, latch disconnected.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_we    <= 1'b0;
      r_owner <= OWN_CPU;
      r_addr  <= 16'h0000;
      r_busy  <= 1'b0;
      r_dl1   <= 1'b1;
      r_dl2   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_cap   <= 1'b0;
      r_cack  <= 1'b0;
      r_dack  <= 1'b0;
    end else begin
      r_we    <= w_nxt_we;
      r_owner <= w_nxt_owner;
      r_addr  <= w_nxt_addr;
      r_busy  <= w_nxt_busy;
      r_dl1   <= w_nxt_dl1;
      r_dl2   <= w_nxt_dl2;
      r_rd    <= w_nxt_rd;
      r_wr    <= w_nxt_wr;
      r_cap   <= w_nxt_cap;
      r_cack  <= w_nxt_cack;
      r_dack  <= w_nxt_dack;
    end
  end

  assign bus.addr        = r_addr;
  assign bus.DL_Control1 = r_dl1;
  assign bus.DL_Control2 = r_dl2;
  assign bus.dl_capture  = r_cap;
  assign bus.rd          = r_rd;
  assign bus.wr          = r_wr;
  assign bus.cpu_ack     = r_cack;
  assign bus.dma_ack     = r_dack;
  assign bus.owner       = r_owner;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_dl_bus_sequencer.sv
// Bench for dl_bus_sequencer: two instances (DMA_BURST=4 and 0) share stimulus and are
// checked every cycle against a transaction-level model plus directed scenario checks.
module tb_dl_bus_sequencer;
  import dl_seq_pkg::*;

  localparam logic [24:0] RST_VEC = 25'h0000100;

  logic        clk;
  logic        rst;
  logic        creq, cwe, dreq, dwe;
  logic [15:0] caddr, daddr;

  int total = 0;
  int bad   = 0;

  dl_bus_sequencer_if bus4();
  dl_bus_sequencer_if bus0();

  assign bus4.cpu_req = creq;  assign bus0.cpu_req = creq;
  assign bus4.cpu_we  = cwe;   assign bus0.cpu_we  = cwe;
  assign bus4.cpu_addr = caddr; assign bus0.cpu_addr = caddr;
  assign bus4.dma_req = dreq;  assign bus0.dma_req = dreq;
  assign bus4.dma_we  = dwe;   assign bus0.dma_we  = dwe;
  assign bus4.dma_addr = daddr; assign bus0.dma_addr = daddr;

  dl_bus_sequencer #(.DMA_BURST(4)) dut4 (.CLK(clk), .RESET(rst), .bus(bus4));
  dl_bus_sequencer #(.DMA_BURST(0)) dut0 (.CLK(clk), .RESET(rst), .bus(bus0));

  wire [24:0] o4 = {bus4.addr, bus4.DL_Control1, bus4.DL_Control2, bus4.dl_capture,
                    bus4.rd, bus4.wr, bus4.cpu_ack, bus4.dma_ack, bus4.owner, bus4.busy};
  wire [24:0] o0 = {bus0.addr, bus0.DL_Control1, bus0.DL_Control2, bus0.dl_capture,
                    bus0.rd, bus0.wr, bus0.cpu_ack, bus0.dma_ack, bus0.owner, bus0.busy};

  // Model: pos = T-state number of the current access (0 = no access).
  typedef struct {
    int          pos;
    bit          we;
    bit          own;
    logic [15:0] a;
    int          run;
  } mdl_t;

  mdl_t m4, m0;

  function automatic mdl_t mstep(input mdl_t m, input int burst);
    mdl_t n;
    bit   cpu_turn;
    n = m;
    if (rst) begin
      n = '{pos: 0, we: 1'b0, own: 1'b0, a: 16'h0000, run: 0};
      return n;
    end
    if (m.pos == 0 || m.pos == 4) begin
      cpu_turn = (burst != 0) && creq && (m.run >= burst);
      if (dreq && !cpu_turn) begin
        n.pos = 1; n.own = 1'b1; n.we = dwe; n.a = daddr;
        n.run = creq ? ((m.run < burst) ? m.run + 1 : burst) : 0;
      end else if (creq) begin
        n.pos = 1; n.own = 1'b0; n.we = cwe; n.a = caddr; n.run = 0;
      end else begin
        n.pos = 0; n.run = 0;
      end
    end else begin
      n.pos = m.pos + 1;
    end
    return n;
  endfunction

  function automatic logic [24:0] mexp(input mdl_t m);
    return {m.a, m.pos == 0, m.pos == 1 && m.we, m.pos == 3 && !m.we,
            (m.pos == 2 || m.pos == 3) && !m.we, (m.pos == 2 || m.pos == 3) && m.we,
            m.pos == 4 && !m.own, m.pos == 4 && m.own, m.own, m.pos != 0};
  endfunction

  always @(posedge clk) begin
    m4 = mstep(m4, 4);
    m0 = mstep(m0, 0);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1; creq = 1'b0; dreq = 1'b0; cwe = 1'b0; dwe = 1'b0;
    caddr = 16'h0; daddr = 16'h0;
    repeat (3) @(negedge clk);
    total += 2;
    if (o4 !== RST_VEC) begin bad++; $display("FAIL reset_b4 got=%h want=%h", o4, RST_VEC); end
    if (o0 !== RST_VEC) begin bad++; $display("FAIL reset_b0 got=%h want=%h", o0, RST_VEC); end
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    logic [3:0] want;
    creq = 1'b1; cwe = 1'b0; caddr = 16'hC000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total += 3;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL read_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL read_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      case (c)
        1: want = 4'b0000;
        2: want = 4'b1000;
        3: want = 4'b1100;
        4: want = 4'b0010;
        default: want = 4'b0001;
      endcase
      if ({bus4.rd, bus4.dl_capture, bus4.cpu_ack, bus4.DL_Control1} !== want) begin
        bad++;
        $display("FAIL read_strobes cyc=%0d got=%b want=%b", c, {bus4.rd, bus4.dl_capture, bus4.cpu_ack, bus4.DL_Control1}, want);
      end
      if (c == 1) begin
        total++;
        if (bus4.addr !== 16'hC000) begin bad++; $display("FAIL read_addr got=%h want=C000", bus4.addr); end
      end
      if (c == 4) creq = 1'b0;
    end
  endtask

  task automatic test_cpu_write();
    creq = 1'b1; cwe = 1'b1; caddr = 16'hFF80;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total += 3;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL write_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL write_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      if ({bus4.rd, bus4.DL_Control2, bus4.wr} !== {1'b0, c == 1, c == 2 || c == 3}) begin
        bad++;
        $display("FAIL write_strobes cyc=%0d got=%b want=%b", c, {bus4.rd, bus4.DL_Control2, bus4.wr}, {1'b0, c == 1, c == 2 || c == 3});
      end
      if (c == 4) creq = 1'b0;
    end
  endtask

  task automatic test_contention();
    bit q4[$];
    int cacks0, dacks0;
    cacks0 = 0; dacks0 = 0;
    creq = 1'b1; dreq = 1'b1;
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      total += 3;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL cont_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL cont_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      if (bus4.busy !== (c <= 100)) begin bad++; $display("FAIL cont_busy cyc=%0d got=%b want=%b", c, bus4.busy, c <= 100); end
      if (bus4.dma_ack === 1'b1) q4.push_back(1'b1);
      if (bus4.cpu_ack === 1'b1) q4.push_back(1'b0);
      if (bus0.cpu_ack === 1'b1) cacks0++;
      if (bus0.dma_ack === 1'b1) dacks0++;
      cwe = 1'($urandom); dwe = 1'($urandom);
      caddr = 16'($urandom); daddr = 16'($urandom);
      if (c == 100) begin creq = 1'b0; dreq = 1'b0; end
    end
    total += 3;
    if (q4.size() != 25) begin bad++; $display("FAIL cont_ack_count got=%0d want=25", q4.size()); end
    if (cacks0 != 0) begin bad++; $display("FAIL strict_cpu_acks got=%0d want=0", cacks0); end
    if (dacks0 != 25) begin bad++; $display("FAIL strict_dma_acks got=%0d want=25", dacks0); end
    for (int i = 0; i < q4.size(); i++) begin
      total++;
      if (q4[i] !== (i % 5 != 4)) begin bad++; $display("FAIL cont_order idx=%0d got_dma=%b want_dma=%b", i, q4[i], i % 5 != 4); end
    end
  endtask

  task automatic test_back_to_back();
    creq = 1'b1; dreq = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      total += 3;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL b2b_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL b2b_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      if ({bus4.cpu_ack, bus4.busy, bus4.DL_Control1} !== {c % 4 == 0 && c <= 12, c <= 12, c > 12}) begin
        bad++;
        $display("FAIL b2b_ctrl cyc=%0d got=%b want=%b", c, {bus4.cpu_ack, bus4.busy, bus4.DL_Control1}, {c % 4 == 0 && c <= 12, c <= 12, c > 12});
      end
      cwe = 1'($urandom); caddr = 16'($urandom);
      if (c == 12) creq = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    creq = 1'b0; dreq = 1'b1; dwe = 1'b1; daddr = 16'h1234;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total += 2;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL rstmid_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL rstmid_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      if (c == 3) begin
        total++;
        if (o4 !== RST_VEC) begin bad++; $display("FAIL rstmid_vals got=%h want=%h", o4, RST_VEC); end
      end
      if (c == 4) begin
        total++;
        if ({bus4.busy, bus4.DL_Control1, bus4.DL_Control2, bus4.addr} !== {1'b1, 1'b0, 1'b1, 16'h1234}) begin
          bad++;
          $display("FAIL rstmid_refetch got=%h want=%h", {bus4.busy, bus4.DL_Control1, bus4.DL_Control2, bus4.addr}, {1'b1, 1'b0, 1'b1, 16'h1234});
        end
      end
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
      if (c == 7) dreq = 1'b0;
    end
  endtask

  task automatic test_withdraw();
    creq = 1'b1; cwe = 1'b0; caddr = 16'($urandom); dreq = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total += 3;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL wdraw_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL wdraw_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      if ({bus4.cpu_ack, bus4.busy} !== {c == 4, c <= 4}) begin
        bad++;
        $display("FAIL wdraw_ctrl cyc=%0d got=%b want=%b", c, {bus4.cpu_ack, bus4.busy}, {c == 4, c <= 4});
      end
      if (c == 2) creq = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      total += 2;
      if (o4 !== mexp(m4)) begin bad++; $display("FAIL rand_b4 cyc=%0d got=%h want=%h", c, o4, mexp(m4)); end
      if (o0 !== mexp(m0)) begin bad++; $display("FAIL rand_b0 cyc=%0d got=%h want=%h", c, o0, mexp(m0)); end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) rst = 1'b1;
      if (creq && bus4.cpu_ack) creq = 1'($urandom_range(0, 1));
      else if (!creq) creq = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 29) == 0) creq = 1'b0;
      if (dreq && bus4.dma_ack) dreq = 1'($urandom_range(0, 1));
      else if (!dreq) dreq = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 29) == 0) dreq = 1'b0;
      cwe = 1'($urandom); dwe = 1'($urandom);
      caddr = 16'($urandom); daddr = 16'($urandom);
    end
  endtask

  initial begin
    m4 = '{pos: 0, we: 1'b0, own: 1'b0, a: 16'h0000, run: 0};
    m0 = m4;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
